supernova_cdb_arbiter: RTL and testbench
========================================

// Module: supernova_cdb_arbiter
// PURPOSE
//  Shares NUM_CDB common-data-bus / ROB-writeback ports among NUM_REQ execution units
//  (ALUs, MDU, LSU load-return). Picks up to NUM_CDB ready results per cycle, round-robin.
//  Registers the picks onto the CDB; they feed RS wakeup and ROB writeback.
//  Sits between the execution units and the RS/ROB.
// PARAMETERS
//  NUM_REQ   4  number of requesting execution units (>= NUM_CDB, >= 2)
//  NUM_CDB   2  number of CDB/writeback ports driven per cycle
//  Tag, ROB-index and data widths come from supernova_pkg/stu_pkg (GPR_TAG_WIDTH, ROB_IDX_WIDTH, REG_WIDTH).
// PORTS
//  clk                 in   1                  sole clock, rising edge
//  rst                 in   1                  asynchronous, active-high reset
//  redirect_valid_in   in   1                  pipeline flush
//  req_valid_in        in   NUM_REQ            unit i has a result
//  req_wb_in           in   NUM_REQ x cdb_wb_t result payload per unit
//  req_ready_out       out  NUM_REQ            unit i granted this cycle (combinational)
//  cdb_valid_out       out  NUM_CDB            CDB port k carries a result
//  cdb_wb_out          out  NUM_CDB x cdb_wb_t payload on port k (tag, data, rob_idx, exception)
//  cdb_src_out         out  NUM_CDB x $clog2(NUM_REQ)  index of the unit that won port k (debug/perf)
// BEHAVIOUR
//  - Handshake: a transfer occurs when req_valid_in[i] && req_ready_out[i]. The unit holds
//    valid and payload stable until the transfer. req_ready_out never depends on the same-cycle
//    payload, only on req_valid_in, rr_ptr and redirect_valid_in.
//  - Pick: scan units rr_ptr, rr_ptr+1, ... mod NUM_REQ. The first NUM_CDB valid units are granted.
//    The k-th grant in scan order goes to port k. Ports beyond the grant count are idle.
//  - Latency: exactly 1 cycle. The payload granted at edge t appears on cdb_*_out after edge t.
//    Output registers load every cycle; cdb_valid_out[k] is 0 when port k is unassigned.
//  - The CDB has no backpressure. Every registered output is consumed in its cycle.
//  - rr_ptr update: if at least one grant occurs, rr_ptr <= (index of last granted unit + 1)
//    mod NUM_REQ, wrapping NUM_REQ-1 -> 0. With no grants, rr_ptr holds.
//  - Starvation bound: any continuously valid unit is granted within ceil(NUM_REQ/NUM_CDB) cycles.
//  - Flush: while redirect_valid_in=1, req_ready_out=0 and nothing is granted.
//    cdb_valid_out goes to 0 after the edge; a result already registered on the CDB in the
//    flush cycle stays visible for that cycle (the ROB discards it). rr_ptr holds.
//  - Reset (async, any time, including mid-transfer): cdb_valid_out=0, cdb_wb_out=0,
//    cdb_src_out=0, rr_ptr=0. req_ready_out=0 while rst=1.
//  - Simultaneous: all NUM_REQ valid -> exactly NUM_CDB grants. Fewer valid than ports ->
//    all valid units are granted in the same cycle. Granting one unit to two ports is illegal
//    and must never happen.
//  - Wrap-around: with rr_ptr=NUM_REQ-1 the scan continues at unit 0 within the same cycle.
// STRUCTURE
//  - supernova_pkg: typedef cdb_wb_t {gpr_tag, data, rob_idx, exception}; constant NUM_CDB_PORTS.
//  - Sub-module supernova_rr_picker: combinational, parameterised (N, M).
//    Inputs: request vector, start pointer.
//    Outputs: M one-hot grant vectors, M valid bits, last-granted index.
//  - Top level contains rr_ptr, the output registers and flush/reset gating.
// TESTING
//  1 Reset: rst=1 mid-stream with req_valid=4'b1111 -> cdb_valid_out=0 and req_ready=0 while
//    rst=1; after release the first grants are units 0,1 on ports 0,1.
//  2 Saturation: req_valid=1111 held for 4 cycles -> grants {0,1},{2,3},{0,1},{2,3};
//    rr_ptr sequence 0,2,0,2.
//  3 Sparse/wrap: rr_ptr=3, req_valid=1001 -> unit 3 on port0, unit 0 on port1, next rr_ptr=1.
//    Then rr_ptr=3, req_valid=0100 -> unit 2 on port0, port1 idle, next rr_ptr=3.
//  4 Latency/payload: unit1 tag=0x2A, data=0xDEADBEEF, rob=5, exc=1 granted at edge t ->
//    after edge t, port0 shows exactly that payload with cdb_src_out=1; the next cycle
//    cdb_valid=0 if idle.
//  5 Flush: redirect_valid_in=1 with req_valid=1111 -> req_ready=0, cdb_valid=0 next cycle,
//    rr_ptr unchanged; the following cycle grants resume from the same rr_ptr.
//  6 Fairness (random): 10k cycles, random valid with hold-until-ready -> no unit waits more
//    than ceil(NUM_REQ/NUM_CDB) cycles; no duplicate or lost results (scoreboard).

Source files
------------

// File: rtl/supernova_pkg.sv
// Shared types and widths for the CDB / ROB writeback path.
package supernova_pkg;

  localparam int GPR_TAG_WIDTH = 7;
  localparam int ROB_IDX_WIDTH = 6;
  localparam int REG_WIDTH     = 32;
  localparam int NUM_CDB_PORTS = 2;

  // One writeback result as carried on a CDB port.
  typedef struct packed {
    logic [GPR_TAG_WIDTH-1:0] gpr_tag;
    logic [REG_WIDTH-1:0]     data;
    logic [ROB_IDX_WIDTH-1:0] rob_idx;
    logic                     exception;
  } cdb_wb_t;

  // Increment a ring index, wrapping n-1 back to 0.
  function automatic int ptr_wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/supernova_cdb_arbiter_if.sv
// Request side (execution units) and CDB side of the writeback arbiter.
// master = execution units / consumers, slave = the arbiter.
interface supernova_cdb_arbiter_if
  import supernova_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int NUM_CDB = NUM_CDB_PORTS
);

  logic                                      redirect_valid_in;
  logic [NUM_REQ-1:0]                        req_valid_in;
  cdb_wb_t [NUM_REQ-1:0]                     req_wb_in;
  logic [NUM_REQ-1:0]                        req_ready_out;
  logic [NUM_CDB-1:0]                        cdb_valid_out;
  cdb_wb_t [NUM_CDB-1:0]                     cdb_wb_out;
  logic [NUM_CDB-1:0][$clog2(NUM_REQ)-1:0]   cdb_src_out;

  modport slave (
    input  redirect_valid_in, req_valid_in, req_wb_in,
    output req_ready_out, cdb_valid_out, cdb_wb_out, cdb_src_out
  );

  modport master (
    output redirect_valid_in, req_valid_in, req_wb_in,
    input  req_ready_out, cdb_valid_out, cdb_wb_out, cdb_src_out
  );

endinterface

// File: rtl/supernova_rr_picker.sv
// Combinational round-robin picker: grants up to M of N requests, scanning
// from start upward with wrap. The k-th grant in scan order lands on port k.
module supernova_rr_picker #(
  parameter int N = 4,
  parameter int M = 2
) (
  input  logic [N-1:0]          req,
  input  logic [$clog2(N)-1:0]  start,
  output logic [M-1:0][N-1:0]   gnt,
  output logic [M-1:0]          gnt_vld,
  output logic [$clog2(N)-1:0]  last_idx
);

  localparam int IW = $clog2(N);
  localparam int PW = IW + 1;
  localparam int CW = $clog2(M + 1);

  logic [PW-1:0] pos;
  logic [IW-1:0] idx;
  logic [CW-1:0] cnt;

  // Walk the ring once from start; each valid unit takes the next free port.
  always_comb begin
    gnt      = '0;
    gnt_vld  = '0;
    last_idx = '0;
    cnt      = '0;
    pos      = '0;
    idx      = '0;
    for (int j = 0; j < N; j++) begin
      pos = {1'b0, start} + PW'(j);
      if (pos >= PW'(N)) pos = pos - PW'(N);
      idx = pos[IW-1:0];
      if (req[idx] && (cnt < CW'(M))) begin
        for (int k = 0; k < M; k++) begin
          if (cnt == CW'(k)) begin
            gnt[k][idx] = 1'b1;
            gnt_vld[k]  = 1'b1;
          end
        end
        last_idx = idx;
        cnt      = cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/supernova_cdb_arbiter.sv
// Shares NUM_CDB CDB/writeback ports among NUM_REQ execution units.
// Round-robin pick each cycle, results registered onto the CDB one cycle later.
module supernova_cdb_arbiter
  import supernova_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int NUM_CDB = NUM_CDB_PORTS
) (
  input  logic                    clk,
  input  logic                    rst,
  supernova_cdb_arbiter_if.slave  bus
);

  localparam int SRC_W = $clog2(NUM_REQ);

  logic [SRC_W-1:0]                 rr_ptr;
  logic [NUM_CDB-1:0][NUM_REQ-1:0]  gnt;
  logic [NUM_CDB-1:0]               gnt_vld;
  logic [SRC_W-1:0]                 last_idx;
  logic                             flush;
  logic [NUM_REQ-1:0]               ready;

  logic [NUM_CDB-1:0]               vld_p0;
  cdb_wb_t [NUM_CDB-1:0]            wb_p0;
  logic [NUM_CDB-1:0][SRC_W-1:0]    src_p0;

  logic [NUM_CDB-1:0]               vld_p1;
  cdb_wb_t [NUM_CDB-1:0]            wb_p1;
  logic [NUM_CDB-1:0][SRC_W-1:0]    src_p1;

  assign flush = bus.redirect_valid_in;

  supernova_rr_picker #(
    .N (NUM_REQ),
    .M (NUM_CDB)
  ) u_picker (
    .req      (bus.req_valid_in),
    .start    (rr_ptr),
    .gnt      (gnt),
    .gnt_vld  (gnt_vld),
    .last_idx (last_idx)
  );

  // p0: grants gated by flush/reset; ports steer the one-hot winner's payload.
  always_comb begin
    ready  = '0;
    vld_p0 = '0;
    wb_p0  = '0;
    src_p0 = '0;
    if (!flush) begin
      vld_p0 = gnt_vld;
      for (int k = 0; k < NUM_CDB; k++) begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (gnt[k][i]) begin
            wb_p0[k]  = bus.req_wb_in[i];
            src_p0[k] = SRC_W'(i);
          end
        end
      end
      if (!rst) begin
        for (int k = 0; k < NUM_CDB; k++) ready = ready | gnt[k];
      end
    end
  end

  // p1: CDB output registers load every cycle; pointer advances past the last winner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
      vld_p1 <= '0;
      wb_p1  <= '0;
      src_p1 <= '0;
    end else begin
      vld_p1 <= vld_p0;
      wb_p1  <= wb_p0;
      src_p1 <= src_p0;
      if (|vld_p0) rr_ptr <= SRC_W'(ptr_wrap_inc(int'(last_idx), NUM_REQ));
    end
  end

  assign bus.req_ready_out = ready;
  assign bus.cdb_valid_out = vld_p1;
  assign bus.cdb_wb_out    = wb_p1;
  assign bus.cdb_src_out   = src_p1;

endmodule

// File: tb/tb_supernova_cdb_arbiter.sv
// Scoreboard bench for supernova_cdb_arbiter: stimulus pushes expected CDB
// contents per cycle, a monitor pops and compares after each rising edge.
module tb_supernova_cdb_arbiter;
  import supernova_pkg::*;

  localparam int NR = 4;
  localparam int NC = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  supernova_cdb_arbiter_if #(.NUM_REQ(NR), .NUM_CDB(NC)) bus ();

  supernova_cdb_arbiter #(.NUM_REQ(NR), .NUM_CDB(NC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic                  ordered;
    logic [NR-1:0]         mask;
    logic [NC-1:0]         vld;
    logic [NC-1:0][1:0]    src;
    cdb_wb_t [NR-1:0]      wb;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic cdb_wb_t base_payload(input int i);
    cdb_wb_t p;
    p.gpr_tag   = 7'(16 + i);
    p.data      = 32'hA000_0000 | 32'(i);
    p.rob_idx   = 6'(i);
    p.exception = 1'b0;
    return p;
  endfunction

  task automatic check_out(input exp_t e);
    logic          ok;
    logic [NR-1:0] seen;
    int            s;
    ok   = 1'b1;
    seen = '0;
    for (int k = 0; k < NC; k++) begin
      if (bus.cdb_valid_out[k]) begin
        s = int'(bus.cdb_src_out[k]);
        if (seen[s] || !e.mask[s]) ok = 1'b0;
        if (bus.cdb_wb_out[k] != e.wb[s]) ok = 1'b0;
        seen[s] = 1'b1;
      end
      if (e.ordered) begin
        if (bus.cdb_valid_out[k] != e.vld[k]) ok = 1'b0;
        if (e.vld[k] && (bus.cdb_src_out[k] != e.src[k])) ok = 1'b0;
      end
    end
    if (seen != e.mask) ok = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL cdb_out t=%0t: got vld=%b src=%0d,%0d data=%h,%h seen=%b; want vld=%b src=%0d,%0d units=%b",
               $time, bus.cdb_valid_out, bus.cdb_src_out[0], bus.cdb_src_out[1],
               bus.cdb_wb_out[0].data, bus.cdb_wb_out[1].data, seen,
               e.vld, e.src[0], e.src[1], e.mask);
    end
  endtask

  // Monitor: one expectation per cycle, compared just after the rising edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) check_out(exp_q.pop_front());
  end

  task automatic chk_rdy(input logic [NR-1:0] want, input string name);
    checks++;
    if (bus.req_ready_out !== want) begin
      errors++;
      $display("FAIL %s: req_ready=%b expected %b", name, bus.req_ready_out, want);
    end
  endtask

  task automatic chk_rst(input string name);
    checks++;
    if (bus.req_ready_out !== '0 || bus.cdb_valid_out !== '0 ||
        bus.cdb_wb_out !== '0 || bus.cdb_src_out !== '0) begin
      errors++;
      $display("FAIL %s: ready=%b cdb_valid=%b src=%0d,%0d expected all zero",
               name, bus.req_ready_out, bus.cdb_valid_out,
               bus.cdb_src_out[0], bus.cdb_src_out[1]);
    end
  endtask

  // Drive one cycle of requests, check grants, queue the CDB contents due after the edge.
  task automatic step(input logic redir, input logic [NR-1:0] v, input logic [NR-1:0] rdy,
                      input logic [NC-1:0] ev, input logic [1:0] s0, input logic [1:0] s1,
                      input string name);
    exp_t e;
    @(negedge clk);
    bus.redirect_valid_in = redir;
    bus.req_valid_in      = v;
    #1;
    chk_rdy(rdy, name);
    e         = '0;
    e.ordered = 1'b1;
    e.vld     = ev;
    e.src[0]  = s0;
    e.src[1]  = s1;
    if (ev[0]) e.mask[s0] = 1'b1;
    if (ev[1]) e.mask[s1] = 1'b1;
    e.wb      = bus.req_wb_in;
    exp_q.push_back(e);
  endtask

  logic [NR-1:0] pend;
  logic [NR-1:0] rdy_s;
  int            wait_c [NR];
  int            seqn;
  int            want_n;
  exp_t          er;

  initial begin
    bus.redirect_valid_in = 1'b0;
    bus.req_valid_in      = '1;
    for (int i = 0; i < NR; i++) bus.req_wb_in[i] = base_payload(i);

    // Reset with all units requesting
    repeat (2) @(negedge clk);
    #1 chk_rst("reset_initial");
    @(posedge clk);
    #3 rst = 1'b0;

    // Reset mid-stream: pointer must return to 0
    step(1'b0, 4'b1111, 4'b0011, 2'b11, 2'd0, 2'd1, "t1_pre");
    @(posedge clk);
    #3 rst = 1'b1;
    #1 chk_rst("reset_async");
    @(negedge clk);
    #1 chk_rst("reset_hold");
    @(posedge clk);
    #3 rst = 1'b0;

    // Saturation: {0,1},{2,3},{0,1},{2,3}
    step(1'b0, 4'b1111, 4'b0011, 2'b11, 2'd0, 2'd1, "t1_first");
    step(1'b0, 4'b1111, 4'b1100, 2'b11, 2'd2, 2'd3, "t2_sat1");
    step(1'b0, 4'b1111, 4'b0011, 2'b11, 2'd0, 2'd1, "t2_sat2");
    step(1'b0, 4'b1111, 4'b1100, 2'b11, 2'd2, 2'd3, "t2_sat3");

    // Sparse and wrap
    step(1'b0, 4'b0100, 4'b0100, 2'b01, 2'd2, 2'd0, "t3_to_ptr3");
    step(1'b0, 4'b1001, 4'b1001, 2'b11, 2'd3, 2'd0, "t3_wrap");
    step(1'b0, 4'b0100, 4'b0100, 2'b01, 2'd2, 2'd0, "t3_back_ptr3");
    step(1'b0, 4'b0100, 4'b0100, 2'b01, 2'd2, 2'd0, "t3_single");
    step(1'b0, 4'b1111, 4'b1001, 2'b11, 2'd3, 2'd0, "t3_ptr_held3");

    // Latency and payload integrity (pointer now 1)
    step(1'b0, 4'b0000, 4'b0000, 2'b00, 2'd0, 2'd0, "t4_idle_a");
    bus.req_wb_in[1].gpr_tag   = 7'h2A;
    bus.req_wb_in[1].data      = 32'hDEADBEEF;
    bus.req_wb_in[1].rob_idx   = 6'd5;
    bus.req_wb_in[1].exception = 1'b1;
    step(1'b0, 4'b0010, 4'b0010, 2'b01, 2'd1, 2'd0, "t4_payload");
    step(1'b0, 4'b0000, 4'b0000, 2'b00, 2'd0, 2'd0, "t4_idle_b");
    checks++;
    if (bus.cdb_valid_out !== 2'b01 || bus.cdb_src_out[0] !== 2'd1 ||
        bus.cdb_wb_out[0] !== {7'h2A, 32'hDEADBEEF, 6'd5, 1'b1}) begin
      errors++;
      $display("FAIL t4_exact: vld=%b src=%0d wb=%h expected vld=01 src=1 wb=%h",
               bus.cdb_valid_out, bus.cdb_src_out[0], bus.cdb_wb_out[0],
               {7'h2A, 32'hDEADBEEF, 6'd5, 1'b1});
    end
    bus.req_wb_in[1] = base_payload(1);

    // Flush (pointer now 2)
    step(1'b0, 4'b0001, 4'b0001, 2'b01, 2'd0, 2'd0, "t5_pre");
    step(1'b1, 4'b1111, 4'b0000, 2'b00, 2'd0, 2'd0, "t5_flush");
    checks++;
    if (bus.cdb_valid_out !== 2'b01 || bus.cdb_src_out[0] !== 2'd0) begin
      errors++;
      $display("FAIL t5_visible: vld=%b src0=%0d expected vld=01 src0=0",
               bus.cdb_valid_out, bus.cdb_src_out[0]);
    end
    step(1'b0, 4'b1111, 4'b0110, 2'b11, 2'd1, 2'd2, "t5_resume");
    step(1'b0, 4'b1111, 4'b1001, 2'b11, 2'd3, 2'd0, "t5_wrap");
    step(1'b0, 4'b0111, 4'b0110, 2'b11, 2'd1, 2'd2, "t5_three");
    step(1'b0, 4'b0000, 4'b0000, 2'b00, 2'd0, 2'd0, "t5_idle");

    // Random fairness with hold-until-ready
    pend = '0;
    seqn = 0;
    for (int i = 0; i < NR; i++) wait_c[i] = 0;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      for (int i = 0; i < NR; i++) begin
        if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
          pend[i] = 1'b1;
          seqn++;
          bus.req_wb_in[i].gpr_tag   = 7'(i);
          bus.req_wb_in[i].data      = 32'(seqn);
          bus.req_wb_in[i].rob_idx   = 6'(seqn);
          bus.req_wb_in[i].exception = seqn[0];
          wait_c[i] = 0;
        end
      end
      bus.req_valid_in = pend;
      #1;
      rdy_s  = bus.req_ready_out;
      want_n = ($countones(pend) < NC) ? $countones(pend) : NC;
      checks++;
      if (((rdy_s & ~pend) != '0) || ($countones(rdy_s) != want_n)) begin
        errors++;
        $display("FAIL rand_ready c=%0d: ready=%b valid=%b expected %0d grants",
                 c, rdy_s, pend, want_n);
      end
      for (int i = 0; i < NR; i++) begin
        if (pend[i]) begin
          wait_c[i]++;
          if (rdy_s[i] || wait_c[i] >= 2) begin
            checks++;
            if (!rdy_s[i] || wait_c[i] > 2) begin
              errors++;
              $display("FAIL starve c=%0d unit=%0d: waited %0d cycles, limit 2", c, i, wait_c[i]);
            end
          end
          if (rdy_s[i]) pend[i] = 1'b0;
        end
      end
      er         = '0;
      er.ordered = 1'b0;
      er.mask    = rdy_s;
      er.wb      = bus.req_wb_in;
      exp_q.push_back(er);
    end
    @(negedge clk);
    bus.req_valid_in = '0;

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
